// File: rtl/imem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
//   state_e : arbiter mode (BOOT = loader owns memory, RUN = fetch priority)
//   owner_e : which requester the read data returning next cycle belongs to
package imem_pkg;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    LOADER
  } owner_e;

  // Owner of the read launched by this cycle's grant; writes and idle cycles
  // return nothing.
  function automatic owner_e owner_of(input logic f_gnt, input logic l_gnt,
                                      input logic l_we);
    owner_e o;
    o = NONE;
    if (f_gnt)               o = FETCH;
    else if (l_gnt && !l_we) o = LOADER;
    return o;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the instruction RAM.
//   fetch port  : f_req/f_addr in, f_gnt/f_rvalid/f_rdata/fetch_stall out
//   loader port : l_req/l_we/l_addr/l_wdata in, l_gnt/l_rvalid/l_rdata out
//   RAM port    : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
// slave  = arbiter side, master = requesters + RAM side.
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              fetch_stall;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, fetch_stall,
           l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, fetch_stall,
           l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arbiter_rr_starve.sv
// Loader starvation counter for RUN mode.
//   clk, rst_n : clock, async active-low reset
//   i_run      : arbiter is in RUN
//   i_l_req    : loader request
//   i_l_gnt    : loader granted this cycle
//   o_force    : loader must win this cycle (counter saturated while requesting)
module imem_rr_starve
  import imem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_l_req,
  input  logic i_l_gnt,
  output logic o_force
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_at_max;

  assign w_at_max = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign o_force  = i_run & i_l_req & w_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_run || i_l_gnt || !i_l_req) begin
      r_starve_cnt <= '0;
    end else if (!w_at_max) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing a single-port synchronous-read instruction RAM between the
// fetch stage (read only) and the program loader (read/write).
//   clk, rst_n : clock, async active-low reset
//   boot_mode  : 1 = loader owns the memory, fetch held stalled
//   bus        : fetch, loader and RAM signals (imem_arbiter_if.slave)
// Fetch wins in RUN unless the loader has been starved STARVE_MAX cycles.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           boot_mode,
  imem_arbiter_if.slave  bus
);

  state_e            r_state;
  owner_e            r_owner;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_l_rdata;

  logic w_run;
  logic w_force;
  logic w_f_gnt;
  logic w_l_gnt;
  logic w_stall;

  assign w_run = (r_state == RUN);

  imem_rr_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_run   (w_run),
    .i_l_req (bus.l_req),
    .i_l_gnt (w_l_gnt),
    .o_force (w_force)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      case (r_state)
        BOOT:    if (!boot_mode) r_state <= RUN;
        RUN:     if (boot_mode)  r_state <= BOOT;
        default: r_state <= BOOT;
      endcase
    end
  end

  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    w_stall = 1'b1;
    if (!w_run) begin
      w_l_gnt = bus.l_req;
    end else if (w_force) begin
      w_l_gnt = 1'b1;
    end else begin
      w_f_gnt = bus.f_req;
      w_l_gnt = bus.l_req & ~bus.f_req;
      w_stall = bus.f_req & ~w_f_gnt;
    end
  end

  assign bus.f_gnt       = w_f_gnt;
  assign bus.l_gnt       = w_l_gnt;
  assign bus.fetch_stall = w_stall;

  assign bus.mem_en    = w_f_gnt | w_l_gnt;
  assign bus.mem_we    = w_l_gnt & bus.l_we;
  assign bus.mem_addr  = w_l_gnt ? bus.l_addr  : bus.f_addr;
  assign bus.mem_wdata = w_l_gnt ? bus.l_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= NONE;
      r_f_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      r_owner <= owner_of(w_f_gnt, w_l_gnt, bus.l_we);
      if (r_owner == FETCH)  r_f_rdata <= bus.mem_rdata;
      if (r_owner == LOADER) r_l_rdata <= bus.mem_rdata;
    end
  end

  // RAM data arrives the cycle after the grant, so rvalid/rdata are driven
  // straight from mem_rdata during that cycle to keep 1-cycle latency; the
  // registered copy holds the value afterwards.
  assign bus.f_rvalid = (r_owner == FETCH);
  assign bus.l_rvalid = (r_owner == LOADER);
  assign bus.f_rdata  = (r_owner == FETCH)  ? bus.mem_rdata : r_f_rdata;
  assign bus.l_rdata  = (r_owner == LOADER) ? bus.mem_rdata : r_l_rdata;

endmodule
